// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: valid/ready pipeline register with one-entry skid buffer, flush-to-bubble
// and saturating stall/flush counters.
module pipe_reg_skid #(
    parameter int                DATA_W    = 96,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic              accept, emit, stall_inc;

    assign out_valid = state_q != EMPTY;
    assign in_ready  = state_q != SKID;
    assign out_data  = main_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign stall_inc = out_valid & ~out_ready & ~flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    main_d  = in_data;
                    state_d = FULL;
                end
                FULL: if (accept && emit) begin
                    main_d = in_data;
                end else if (emit) begin
                    main_d  = FLUSH_VAL;
                    state_d = EMPTY;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = SKID;
                end
                SKID: if (emit) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = FLUSH_VAL;
                end
            endcase
        end
        stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= FLUSH_VAL;
            skid_q      <= FLUSH_VAL;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed and random checks of pipe_reg_skid against a queue-based model
// (NOP bubble 0x13, 4-bit counters so saturation is reachable).
module tb_pipe_reg_skid;
    localparam logic [31:0] NOP = 32'h13;

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [3:0]  stall_cnt, flush_cnt;

    int total = 0, bad = 0;
    logic [31:0] q[$];
    logic [31:0] m_stall = 0, m_flush = 0;

    pipe_reg_skid #(.DATA_W(32), .FLUSH_VAL(NOP), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_data", out_data, q.size() > 0 ? q[0] : NOP);
        check("stall_cnt", 32'(stall_cnt), m_stall);
        check("flush_cnt", 32'(flush_cnt), m_flush);
    endtask

    // Apply inputs at a negedge, advance the model over the next posedge, check at next negedge.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic fl, input logic ordy);
        logic acc, em;
        in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
        acc = iv && q.size() < 2;
        em  = q.size() > 0 && ordy;
        if (q.size() > 0 && !ordy && !fl && m_stall < 15) m_stall++;
        if (fl && m_flush < 15) m_flush++;
        if (fl) q.delete();
        else begin
            if (em) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_data", out_data, NOP);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_flush", 32'(flush_cnt), 32'd0);
        q.delete(); m_stall = 0; m_flush = 0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        logic        cur_v;
        logic [31:0] cur_d;
        logic        rdy;
        repeat (2) @(negedge clk);
        do_reset();
        // streaming
        cycle(1, 32'h1, 0, 1); cycle(1, 32'h2, 0, 1); cycle(1, 32'h3, 0, 1); cycle(0, 0, 0, 1);
        // backpressure into skid, then drain in order
        cycle(1, 32'hA, 0, 0); cycle(1, 32'hB, 0, 0); cycle(1, 32'hC, 0, 0); cycle(1, 32'hC, 0, 0);
        cycle(1, 32'hC, 0, 1); cycle(1, 32'hC, 0, 1); cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
        // flush while in skid with an incoming word
        cycle(1, 32'hA, 0, 0); cycle(1, 32'hB, 0, 0); cycle(1, 32'hD, 1, 0); cycle(0, 0, 0, 1);
        // drain to bubble
        cycle(1, 32'h5, 0, 0); cycle(0, 0, 0, 1);
        // stall counter saturation
        cycle(1, 32'h7, 0, 0);
        repeat (20) cycle(0, 0, 0, 0);
        check("stall_sat", 32'(stall_cnt), 32'd15);
        // async reset from skid, between edges
        cycle(1, 32'h8, 0, 0);
        #2;
        do_reset();
        // random traffic; producer holds an offered word until accepted
        cur_v = 1'b1; cur_d = $urandom;
        for (int i = 0; i < 3000; i++) begin
            rdy = q.size() < 2;
            cycle(cur_v, cur_d, ($urandom % 25) == 0, (i % 400) < 60 ? 1'b0 : ($urandom % 10) < 7);
            if (!cur_v || rdy) begin
                cur_v = ($urandom % 3) != 0;
                cur_d = $urandom;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
